ggt_param_core: RTL and testbench

//  Parametrised successor of the fixed 16-bit GCD unit: computes gcd(Zahl1_i, Zahl2_i) for WIDTH-bit

---
 rtl/ggt_pkg.sv | 24 ++
 rtl/ggt_param_ctrl.sv | 109 ++++++++++
 rtl/ggt_param_core.sv | 91 +++++++++
 tb/tb_ggt_param_core.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ggt_pkg.sv
// Shared definitions for the parametrised GCD engine: FSM state encoding and the
// controller-to-datapath command bundle.
package ggt_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StCheck  = 3'd1,
      StShift  = 3'd2,
      StReduce = 3'd3,
      StDone   = 3'd4
   } ggt_state_e;

   typedef struct packed {
      logic load;
      logic set_or;
      logic shift_both;
      logic shift_a;
      logic shift_b;
      logic sub_ab;
      logic sub_ba;
      logic set_shl;
   } ggt_cmd_t;

endpackage

// File: rtl/ggt_param_ctrl.sv
// Binary-GCD sequencer: walks IDLE/CHECK/SHIFT/REDUCE/DONE from datapath flags and
// keeps the saturating per-request cycle counter.
module ggt_param_ctrl
   import ggt_pkg::*;
#(
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             start_i,
   input  logic             a_zero_i,
   input  logic             b_zero_i,
   input  logic             a_even_i,
   input  logic             b_even_i,
   input  logic             a_eq_b_i,
   input  logic             a_gt_b_i,
   output ggt_cmd_t         cmd_o,
   output logic             ready_o,
   output logic             valid_o,
   output logic [CNT_W-1:0] cycles_o
);

   localparam logic [CNT_W-1:0] CntMax = '1;

   ggt_state_e       state_q, state_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [CNT_W-1:0] cycles_q, cycles_d;
   logic [CNT_W:0]   count_p2;

   // Results are published on entry to DONE: the entry cycle and DONE itself still count.
   assign count_p2 = {1'b0, count_q} + (CNT_W + 1)'(2);

   always_comb begin
      state_d  = state_q;
      cmd_o    = '0;
      count_d  = count_q;
      cycles_d = cycles_q;

      if (state_q != StIdle) begin
         count_d = (count_q == CntMax) ? CntMax : count_q + CNT_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               cmd_o.load = 1'b1;
               count_d    = '0;
               state_d    = StCheck;
            end
         end
         StCheck: begin
            if (a_zero_i || b_zero_i) begin
               cmd_o.set_or = 1'b1;
               state_d      = StDone;
            end else begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (a_even_i && b_even_i) begin
               cmd_o.shift_both = 1'b1;
            end else begin
               state_d = StReduce;
            end
         end
         StReduce: begin
            if (a_eq_b_i) begin
               cmd_o.set_shl = 1'b1;
               state_d       = StDone;
            end else if (a_even_i) begin
               cmd_o.shift_a = 1'b1;
            end else if (b_even_i) begin
               cmd_o.shift_b = 1'b1;
            end else if (a_gt_b_i) begin
               cmd_o.sub_ab = 1'b1;
            end else begin
               cmd_o.sub_ba = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_d == StDone && state_q != StDone) begin
         cycles_d = (count_p2 > {1'b0, CntMax}) ? CntMax : count_p2[CNT_W-1:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= StIdle;
         count_q  <= '0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         cycles_q <= cycles_d;
      end
   end

   assign ready_o  = (state_q == StIdle);
   assign valid_o  = (state_q == StDone);
   assign cycles_o = cycles_q;

endmodule

// File: rtl/ggt_param_core.sv
// WIDTH-bit binary (Stein) GCD engine with start/ready handshake, zero flag and cycle count.
// Holds the a/b/k datapath; sequencing lives in ggt_param_ctrl.
module ggt_param_core
   import ggt_pkg::*;
#(
   parameter int unsigned WIDTH = 16,
   parameter int unsigned KW    = 5,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] Zahl1_i,
   input  logic [WIDTH-1:0] Zahl2_i,
   output logic             ready_o,
   output logic             valid_o,
   output logic [WIDTH-1:0] ergebnis_o,
   output logic             zero_o,
   output logic [CNT_W-1:0] cycles_o
);

   ggt_cmd_t         cmd;
   logic [WIDTH-1:0] a_q, b_q;
   logic [KW-1:0]    k_q;
   logic [WIDTH-1:0] res_q;
   logic             zero_q;
   logic             a_zero, b_zero, a_even, b_even, a_eq_b, a_gt_b;

   assign a_zero = (a_q == '0);
   assign b_zero = (b_q == '0);
   assign a_even = ~a_q[0];
   assign b_even = ~b_q[0];
   assign a_eq_b = (a_q == b_q);
   assign a_gt_b = (a_q > b_q);

   ggt_param_ctrl #(
      .CNT_W (CNT_W)
   ) u_ctrl (
      .clk_i    (clk),
      .rst_ni   (rst_i),
      .start_i  (start_i),
      .a_zero_i (a_zero),
      .b_zero_i (b_zero),
      .a_even_i (a_even),
      .b_even_i (b_even),
      .a_eq_b_i (a_eq_b),
      .a_gt_b_i (a_gt_b),
      .cmd_o    (cmd),
      .ready_o  (ready_o),
      .valid_o  (valid_o),
      .cycles_o (cycles_o)
   );

   // res is written straight into the output register so it is already new while valid_o=1.
   always_ff @(posedge clk or negedge rst_i) begin
      if (!rst_i) begin
         a_q    <= '0;
         b_q    <= '0;
         k_q    <= '0;
         res_q  <= '0;
         zero_q <= 1'b0;
      end else begin
         if (cmd.load) begin
            a_q <= Zahl1_i;
            b_q <= Zahl2_i;
            k_q <= '0;
         end
         if (cmd.set_or) begin
            res_q  <= a_q | b_q;
            zero_q <= a_zero & b_zero;
         end
         if (cmd.shift_both) begin
            a_q <= a_q >> 1;
            b_q <= b_q >> 1;
            k_q <= k_q + KW'(1);
         end
         if (cmd.shift_a) a_q <= a_q >> 1;
         if (cmd.shift_b) b_q <= b_q >> 1;
         if (cmd.sub_ab)  a_q <= a_q - b_q;
         if (cmd.sub_ba)  b_q <= b_q - a_q;
         if (cmd.set_shl) begin
            res_q  <= a_q << k_q;
            zero_q <= 1'b0;
         end
      end
   end

   assign ergebnis_o = res_q;
   assign zero_o     = zero_q;

endmodule

// File: tb/tb_ggt_param_core.sv
// Self-checking bench for ggt_param_core: directed table, abort/ignore sequences and
// random pairs on WIDTH=16 and WIDTH=8 instances against a Euclid reference.
module tb_ggt_param_core;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        start16, rdy16, val16, zero16;
   logic [15:0] z1_16, z2_16, erg16;
   logic [7:0]  cyc16;
   logic        start8, rdy8, val8, zero8;
   logic [7:0]  z1_8, z2_8, erg8;
   logic [7:0]  cyc8;

   ggt_param_core #(.WIDTH(16), .KW(5), .CNT_W(8)) dut16 (
      .clk(clk), .rst_i(rst_n), .start_i(start16), .Zahl1_i(z1_16), .Zahl2_i(z2_16),
      .ready_o(rdy16), .valid_o(val16), .ergebnis_o(erg16), .zero_o(zero16), .cycles_o(cyc16)
   );

   ggt_param_core #(.WIDTH(8), .KW(4), .CNT_W(8)) dut8 (
      .clk(clk), .rst_i(rst_n), .start_i(start8), .Zahl1_i(z1_8), .Zahl2_i(z2_8),
      .ready_o(rdy8), .valid_o(val8), .ergebnis_o(erg8), .zero_o(zero8), .cycles_o(cyc8)
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [15:0] res;
      logic        z;
      int          cyc;   // -1: cycle count not checked
   } vec_t;

   int tests = 0;
   int fails = 0;
   int vcount16 = 0, vcount8 = 0;
   int exp16 = 0, exp8 = 0;

   always @(negedge clk) begin
      if (val16) vcount16++;
      if (val8)  vcount8++;
   end

   function automatic longint gcd_ref(input longint x, input longint y);
      longint t;
      while (y != 0) begin
         t = x % y;
         x = y;
         y = t;
      end
      return x;
   endfunction

   task automatic check(input string name, input longint act, input longint exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic issue(input bit w8, input logic [15:0] a, input logic [15:0] b);
      int n = 0;
      @(negedge clk);
      while (!(w8 ? rdy8 : rdy16) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) check("ready_timeout", 0, 1);
      if (w8) begin
         start8 = 1'b1; z1_8 = a[7:0]; z2_8 = b[7:0];
      end else begin
         start16 = 1'b1; z1_16 = a; z2_16 = b;
      end
      @(negedge clk);
      start8  = 1'b0;
      start16 = 1'b0;
   endtask

   task automatic wait_done(input bit w8, output logic [15:0] res, output logic z,
                            output logic [7:0] cyc, output bit ok);
      int n = 0;
      ok  = 1'b0;
      res = '0; z = 1'b0; cyc = '0;
      while (n < 300) begin
         if (w8 ? val8 : val16) begin
            res = w8 ? {8'd0, erg8} : erg16;
            z   = w8 ? zero8 : zero16;
            cyc = w8 ? cyc8 : cyc16;
            ok  = 1'b1;
            break;
         end
         @(negedge clk);
         n++;
      end
      if (!ok) check("valid_timeout", 0, 1);
   endtask

   initial begin
      vec_t        tbl[8];
      logic [15:0] res;
      logic        z;
      logic [7:0]  cyc;
      bit          ok;
      int          snap;

      tbl[0] = '{a: 16'd48,    b: 16'd18,    res: 16'd6,     z: 1'b0, cyc: 10};
      tbl[1] = '{a: 16'd0,     b: 16'd0,     res: 16'd0,     z: 1'b1, cyc: 2};
      tbl[2] = '{a: 16'd0,     b: 16'd35,    res: 16'd35,    z: 1'b0, cyc: 2};
      tbl[3] = '{a: 16'd35,    b: 16'd0,     res: 16'd35,    z: 1'b0, cyc: 2};
      tbl[4] = '{a: 16'd65535, b: 16'd1,     res: 16'd1,     z: 1'b0, cyc: -1};
      tbl[5] = '{a: 16'd65535, b: 16'd65535, res: 16'd65535, z: 1'b0, cyc: 4};
      tbl[6] = '{a: 16'd32768, b: 16'd16384, res: 16'd16384, z: 1'b0, cyc: 19};
      tbl[7] = '{a: 16'd12,    b: 16'd8,     res: 16'd4,     z: 1'b0, cyc: 9};

      rst_n = 1'b0;
      start16 = 1'b0; z1_16 = '0; z2_16 = '0;
      start8  = 1'b0; z1_8  = '0; z2_8  = '0;
      #12;
      check("rst_ready", rdy16, 1);
      check("rst_valid", val16, 0);
      check("rst_ergebnis", erg16, 0);
      check("rst_zero", zero16, 0);
      check("rst_cycles", cyc16, 0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         issue(1'b0, tbl[i].a, tbl[i].b);
         exp16++;
         wait_done(1'b0, res, z, cyc, ok);
         if (ok) begin
            check($sformatf("tbl%0d_res", i), res, tbl[i].res);
            check($sformatf("tbl%0d_zero", i), z, tbl[i].z);
            if (tbl[i].cyc >= 0) check($sformatf("tbl%0d_cycles", i), cyc, tbl[i].cyc);
         end
      end

      // start while busy must be ignored
      issue(1'b0, 16'd48, 16'd18);
      exp16++;
      @(negedge clk);
      check("busy_ready", rdy16, 0);
      start16 = 1'b1; z1_16 = 16'd9; z2_16 = 16'd6;
      @(negedge clk);
      start16 = 1'b0;
      wait_done(1'b0, res, z, cyc, ok);
      if (ok) begin
        check("busy_res", res, 6);
        check("busy_cycles", cyc, 10);
      end
      @(negedge clk);
      check("post_done_ready", rdy16, 1);

      // reset in REDUCE aborts the job
      issue(1'b0, 16'd48, 16'd18);
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_ready", rdy16, 1);
      check("abort_valid", val16, 0);
      check("abort_ergebnis", erg16, 0);
      @(negedge clk);
      rst_n = 1'b1;
      snap = vcount16;
      repeat (20) @(negedge clk);
      check("abort_no_valid", vcount16 - snap, 0);
      issue(1'b0, 16'd12, 16'd8);
      exp16++;
      wait_done(1'b0, res, z, cyc, ok);
      if (ok) check("after_abort_res", res, 4);

      // random pairs on both widths
      for (int w = 0; w < 2; w++) begin
         int nruns = (w == 1) ? 800 : 500;
         for (int i = 0; i < nruns; i++) begin
            logic [15:0] a, b;
            a = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
            b = ($urandom_range(0, 9) == 0) ? 16'd0 : 16'($urandom);
            if (w == 1) begin
               a[15:8] = '0;
               b[15:8] = '0;
            end
            issue(w == 1, a, b);
            if (w == 1) exp8++; else exp16++;
            wait_done(w == 1, res, z, cyc, ok);
            if (ok) begin
               check($sformatf("rand_w%0d_%0d_%0d_res", w, a, b), res, gcd_ref(a, b));
               check($sformatf("rand_w%0d_%0d_%0d_zero", w, a, b), z,
                     (a == 0 && b == 0) ? 1 : 0);
            end
         end
      end

      repeat (3) @(negedge clk);
      check("valid_count16", vcount16, exp16);
      check("valid_count8", vcount8, exp8);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
